tri_engine_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one serial triangle engine (3-beat length input, 3-beat cosine output) between NREQ requesters.
- Each requester presents three 8-bit lengths in parallel.
- The block serializes the lengths into the engine, waits for the engine's 3-cycle output burst, and captures the cosines and triangle type.
- It returns the results in parallel to the granted requester.
- Sits between the host-side request ports and the triangle engine's in_valid/in_length/out_valid/out_cos/out_tri interface.

---
 rtl/tri_engine_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_tri_engine_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tri_engine_arbiter.sv
// tri_engine_arbiter: round-robin sharing of one serial triangle engine
// between NREQ requesters. Each grant feeds three lengths into the engine,
// collects the three-beat cosine burst and returns it to the granted port.
// Optional build macro TRI_ARB_TIMEOUT_EN bounds the WAIT state to TIMEOUT
// cycles; without it WAIT is unbounded.
//
// state | meaning
// IDLE  | no transaction; arbitrate when no engine beat is present
// FEED0 | len0 on the engine input (req_ack pulses this cycle)
// FEED1 | len1 on the engine input
// FEED2 | len2 on the engine input
// WAIT  | waiting for the first output beat (cos0 + triangle type)
// CAP1  | expecting the second beat (cos1)
// CAP2  | expecting the third beat (cos2)
// RESP  | drain any extra beats, then publish the result
module tri_engine_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*24-1:0] req_len,
  output logic [NREQ-1:0]   req_ack,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [47:0]       rsp_cos,
  output logic [1:0]        rsp_tri,
  output logic              rsp_err,
  output logic              busy,
  output logic              eng_in_valid,
  output logic [7:0]        eng_in_length,
  input  logic              eng_out_valid,
  input  logic [15:0]       eng_out_cos,
  input  logic [1:0]        eng_out_tri
);

  localparam int IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 4 || TIMEOUT < 1) begin : g_bad_param
    $error("tri_engine_arbiter: NREQ must be 2..4 and TIMEOUT at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_FEED0, S_FEED1, S_FEED2, S_WAIT, S_CAP1, S_CAP2, S_RESP
  } state_t;

  state_t           r_state;
  logic [IW-1:0]    r_rr;
  logic [IW-1:0]    r_idx;
  logic [23:0]      r_len;
  logic [15:0]      r_cos0, r_cos1, r_cos2;
  logic [1:0]       r_tri;
  logic             r_err;
  logic [NREQ-1:0]  r_req_ack;
  logic [NREQ-1:0]  r_rsp_valid;
  logic [47:0]      r_rsp_cos;
  logic [1:0]       r_rsp_tri;
  logic             r_rsp_err;
  logic             r_in_valid;
  logic [7:0]       r_in_length;
`ifdef TRI_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]    r_tcnt;
`endif

  logic [23:0]      w_lens [NREQ];
  logic             w_found;
  logic [IW-1:0]    w_idx;
  logic [IW-1:0]    w_cand;

  // Unpack the per-requester length words
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      w_lens[i] = req_len[24*i +: 24];
    end
  end

  // Round-robin search: walk offsets high to low so the lowest offset from r_rr wins
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_cand  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_cand = IW'((int'(r_rr) + i) % NREQ);
      if (req[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rr        <= '0;
      r_idx       <= '0;
      r_len       <= '0;
      r_cos0      <= '0;
      r_cos1      <= '0;
      r_cos2      <= '0;
      r_tri       <= '0;
      r_err       <= 1'b0;
      r_req_ack   <= '0;
      r_rsp_valid <= '0;
      r_rsp_cos   <= '0;
      r_rsp_tri   <= '0;
      r_rsp_err   <= 1'b0;
      r_in_valid  <= 1'b0;
      r_in_length <= '0;
`ifdef TRI_ARB_TIMEOUT_EN
      r_tcnt      <= '0;
`endif
    end else begin
      r_req_ack   <= '0;
      r_rsp_valid <= '0;
      case (r_state)
        S_IDLE: begin
          // a beat still on the engine output blocks the grant
          if (w_found && !eng_out_valid) begin
            r_idx       <= w_idx;
            r_len       <= w_lens[w_idx];
            r_req_ack   <= NREQ'(1) << w_idx;
            r_cos0      <= '0;
            r_cos1      <= '0;
            r_cos2      <= '0;
            r_tri       <= '0;
            r_err       <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_in_valid  <= 1'b1;
            r_in_length <= w_lens[w_idx][7:0];
            r_state     <= S_FEED0;
          end
        end
        S_FEED0: begin
          if (eng_out_valid) r_err <= 1'b1;
          r_in_length <= r_len[15:8];
          r_state     <= S_FEED1;
        end
        S_FEED1: begin
          if (eng_out_valid) r_err <= 1'b1;
          r_in_length <= r_len[23:16];
          r_state     <= S_FEED2;
        end
        S_FEED2: begin
          if (eng_out_valid) r_err <= 1'b1;
          r_in_valid  <= 1'b0;
          r_in_length <= '0;
`ifdef TRI_ARB_TIMEOUT_EN
          r_tcnt      <= '0;
`endif
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          if (eng_out_valid) begin
            r_cos0  <= eng_out_cos;
            r_tri   <= eng_out_tri;
            r_state <= S_CAP1;
          end
`ifdef TRI_ARB_TIMEOUT_EN
          else if (r_tcnt == TW'(TIMEOUT - 1)) begin
            r_err   <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_tcnt  <= r_tcnt + 1'b1;
          end
`endif
        end
        S_CAP1: begin
          if (eng_out_valid) begin
            r_cos1  <= eng_out_cos;
            r_state <= S_CAP2;
          end else begin
            r_err   <= 1'b1;
            r_cos1  <= '0;
            r_cos2  <= '0;
            r_state <= S_RESP;
          end
        end
        S_CAP2: begin
          if (eng_out_valid) begin
            r_cos2 <= eng_out_cos;
          end else begin
            r_err  <= 1'b1;
            r_cos2 <= '0;
          end
          r_state <= S_RESP;
        end
        S_RESP: begin
          // extra beats are an error; publish only once the engine goes quiet
          if (eng_out_valid) begin
            r_err <= 1'b1;
          end else begin
            r_rsp_cos   <= {r_cos2, r_cos1, r_cos0};
            r_rsp_tri   <= r_tri;
            r_rsp_err   <= r_err;
            r_rsp_valid <= NREQ'(1) << r_idx;
            r_rr        <= (r_idx == IW'(NREQ - 1)) ? '0 : r_idx + 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ack       = r_req_ack;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_cos       = r_rsp_cos;
  assign rsp_tri       = r_rsp_tri;
  assign rsp_err       = r_rsp_err;
  assign busy          = (r_state != S_IDLE);
  assign eng_in_valid  = r_in_valid;
  assign eng_in_length = r_in_length;

endmodule

// File: tb/tb_tri_engine_arbiter.sv
// Scoreboard bench for tri_engine_arbiter: a behavioural engine replies to
// each three-beat feed with a configurable burst, the driver predicts grant,
// feed and response with a round-robin model, and negedge monitors compare.
module tb_tri_engine_arbiter;
  localparam int NREQ = 2;
  localparam int TO   = 20;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req;
  logic [NREQ*24-1:0] req_len;
  logic [NREQ-1:0]   req_ack, rsp_valid;
  logic [47:0]       rsp_cos;
  logic [1:0]        rsp_tri;
  logic              rsp_err, busy, eng_in_valid;
  logic [7:0]        eng_in_length;
  logic              eng_out_valid;
  logic [15:0]       eng_out_cos;
  logic [1:0]        eng_out_tri;

  always #5 clk = ~clk;

  tri_engine_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_len(req_len),
    .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_cos(rsp_cos),
    .rsp_tri(rsp_tri), .rsp_err(rsp_err), .busy(busy),
    .eng_in_valid(eng_in_valid), .eng_in_length(eng_in_length),
    .eng_out_valid(eng_out_valid), .eng_out_cos(eng_out_cos),
    .eng_out_tri(eng_out_tri));

  typedef struct packed {
    logic [NREQ-1:0] onehot;
    logic [47:0]     cos;
    logic [1:0]      tri_v;
    logic            err;
  } rsp_t;

  int vectors = 0;
  int miscompares = 0;
  int rr = 0;
  logic [NREQ-1:0] q_ack[$];
  logic [7:0]      q_len[$];
  rsp_t            q_rsp[$];

  int          cfg_nb = 3;
  int          cfg_dly = 1;
  logic [15:0] cfg_cos [4];
  logic [1:0]  cfg_tri = '0;
  int          stray_req = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural engine: replies after three fed lengths, or on a stray request
  initial begin : engine_model
    int feed_cnt, stray_seen, dly, lnb;
    bit go;
    logic [15:0] lcos [4];
    logic [1:0] ltri;
    feed_cnt = 0; stray_seen = 0;
    eng_out_valid = 1'b0; eng_out_cos = '0; eng_out_tri = '0;
    forever begin
      @(posedge clk); #1;
      go = 1'b0; dly = 0;
      if (!rst_n) begin
        feed_cnt = 0;
      end else begin
        if (eng_in_valid) feed_cnt++;
        if (feed_cnt == 3) begin
          feed_cnt = 0; go = 1'b1; dly = cfg_dly;
        end else if (stray_req != stray_seen) begin
          stray_seen = stray_req; go = 1'b1;
        end
        if (go) begin
          lnb = cfg_nb; lcos = cfg_cos; ltri = cfg_tri;
          repeat (dly) begin @(posedge clk); #1; end
          for (int b = 0; b < lnb; b++) begin
            eng_out_valid = 1'b1;
            eng_out_cos   = lcos[b];
            eng_out_tri   = (b == 0) ? ltri : 2'($urandom);
            @(posedge clk); #1;
          end
          eng_out_valid = 1'b0; eng_out_cos = '0; eng_out_tri = '0;
        end
      end
    end
  end

  // Monitor: feed lengths, grants, responses, engine spacing
  initial begin : monitor
    logic [47:0] last_cos;
    logic prev_eov, prev_in;
    int cyc, last_eov_cyc;
    rsp_t e;
    last_cos = '0; prev_eov = 1'b0; prev_in = 1'b0; cyc = 0; last_eov_cyc = -100;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_cos = '0; prev_eov = 1'b0; prev_in = 1'b0;
      end else begin
        if (eng_in_valid && eng_out_valid) chk("in_out_overlap", 1, 0);
        if (!eng_in_valid) begin
          if (eng_in_length != 0) chk("len_when_idle", 64'(eng_in_length), 0);
        end else if (q_len.size() == 0) begin
          chk("unexpected_feed", 64'(eng_in_length), 0);
        end else begin
          chk("feed_len", 64'(eng_in_length), 64'(q_len.pop_front()));
        end
        if (eng_in_valid && !prev_in)
          chk("idle_gap", 64'((cyc - last_eov_cyc) >= 2), 1);
        if (req_ack != 0) begin
          chk("grant_during_eov", 64'(prev_eov), 0);
          chk("rsp_err_clear", 64'(rsp_err), 0);
          chk("rsp_cos_hold", 64'(rsp_cos), 64'(last_cos));
          chk("busy_on_grant", 64'(busy), 1);
          if (q_ack.size() == 0) chk("unexpected_ack", 64'(req_ack), 0);
          else chk("req_ack", 64'(req_ack), 64'(q_ack.pop_front()));
        end
        if (rsp_valid != 0) begin
          chk("eov_at_rsp", 64'(eng_out_valid), 0);
          if (q_rsp.size() == 0) begin
            chk("unexpected_rsp", 64'(rsp_valid), 0);
          end else begin
            e = q_rsp.pop_front();
            chk("rsp_valid", 64'(rsp_valid), 64'(e.onehot));
            chk("rsp_cos", 64'(rsp_cos), 64'(e.cos));
            chk("rsp_tri", 64'(rsp_tri), 64'(e.tri_v));
            chk("rsp_err", 64'(rsp_err), 64'(e.err));
            last_cos = e.cos;
          end
        end
        prev_eov = eng_out_valid;
        prev_in  = eng_in_valid;
        if (eng_out_valid) last_eov_cyc = cyc;
        cyc++;
      end
    end
  end

  function automatic int model_grant(input logic [NREQ-1:0] mask);
    int idx = -1;
    for (int i = 0; i < NREQ; i++) begin
      int k;
      k = (rr + i) % NREQ;
      if (idx < 0 && mask[k]) idx = k;
    end
    return idx;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_req_ack"}, 64'(req_ack), 0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 0);
    chk({tag, "_rsp_cos"}, 64'(rsp_cos), 0);
    chk({tag, "_rsp_tri"}, 64'(rsp_tri), 0);
    chk({tag, "_rsp_err"}, 64'(rsp_err), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_in_valid"}, 64'(eng_in_valid), 0);
    chk({tag, "_in_length"}, 64'(eng_in_length), 0);
  endtask

  task automatic wait_ack(output bit ok);
    int cyc = 0;
    while (req_ack == 0 && cyc < 30) begin @(posedge clk); #1; cyc++; end
    ok = (req_ack != 0);
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL ack_timeout: got no req_ack, expected one within 30 cycles");
    end
  endtask

  task automatic do_txn(input logic [NREQ-1:0] mask, input logic [23:0] l0, input logic [23:0] l1,
                        input int nb, input int dly, input logic [15:0] c0, input logic [15:0] c1,
                        input logic [15:0] c2, input logic [15:0] c3, input logic [1:0] t,
                        input bit stray, output int lat);
    int idx, cyc;
    logic [23:0] ln;
    rsp_t e;
    bit ok;
    lat = -1;
    idx = model_grant(mask);
    ln = (idx == 1) ? l1 : l0;
    if (stray) begin
      cfg_nb = 3;
      for (int b = 0; b < 4; b++) cfg_cos[b] = 16'($urandom);
      stray_req++;
      cyc = 0;
      while (!eng_out_valid && cyc < 10) begin @(posedge clk); #1; cyc++; end
      if (!eng_out_valid) chk("stray_start", 64'(eng_out_valid), 1);
    end
    cfg_nb = nb; cfg_dly = dly; cfg_tri = t;
    cfg_cos[0] = c0; cfg_cos[1] = c1; cfg_cos[2] = c2; cfg_cos[3] = c3;
    q_ack.push_back(NREQ'(1) << idx);
    q_len.push_back(ln[7:0]); q_len.push_back(ln[15:8]); q_len.push_back(ln[23:16]);
    e.onehot = NREQ'(1) << idx;
    if (nb == 0) begin
      e.cos = '0; e.tri_v = '0; e.err = 1'b1;
    end else begin
      e.cos   = {(nb >= 3) ? c2 : 16'h0, (nb >= 2) ? c1 : 16'h0, c0};
      e.tri_v = t;
      e.err   = (nb != 3);
    end
    q_rsp.push_back(e);
    rr = (idx + 1) % NREQ;
    req_len = {l1, l0};
    req = mask;
    wait_ack(ok);
    req = '0;
    if (!ok) return;
    cyc = 0;
    while (rsp_valid == 0 && cyc < TO + 60) begin @(posedge clk); #1; cyc++; end
    if (rsp_valid == 0) begin
      vectors++; miscompares++;
      $display("FAIL rsp_timeout: got no rsp_valid, expected one within %0d cycles", TO + 60);
    end else begin
      lat = cyc;
    end
  endtask

  task automatic rand_txn(input logic [NREQ-1:0] mask, input int nb, output int lat);
    do_txn(mask, 24'($urandom), 24'($urandom), nb, $urandom_range(1, 3),
           16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
           2'($urandom), 1'b0, lat);
    repeat ($urandom_range(1, 3)) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int lat, idx, r, nb;
    bit ok;
    req = '0; req_len = '0;
    for (int b = 0; b < 4; b++) cfg_cos[b] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // both requesters held high: grants alternate 0,1,0,1
    for (int i = 0; i < 4; i++) rand_txn(2'b11, 3, lat);

    // directed single request on port 0
    do_txn(2'b01, {8'd5, 8'd4, 8'd3}, 24'h0, 3, 2, 16'h2000, 16'h1000, 16'hE000, 16'h0,
           2'd2, 1'b0, lat);
    repeat (2) @(posedge clk); #1;

    // short, very short and long bursts
    rand_txn(2'b01, 2, lat);
    rand_txn(2'b10, 1, lat);
    rand_txn(2'b11, 4, lat);

    // length boundaries forwarded unchanged
    do_txn(2'b10, 24'h0, {8'd128, 8'd255, 8'd0}, 3, 1, 16'h7FFF, 16'h8000, 16'h0001, 16'h0,
           2'd1, 1'b0, lat);
    repeat (2) @(posedge clk); #1;

    // reset during FEED1
    cfg_nb = 3; cfg_dly = 2;
    idx = model_grant(2'b01);
    q_ack.push_back(NREQ'(1) << idx);
    q_len.push_back(8'h11); q_len.push_back(8'h22); q_len.push_back(8'h33);
    req_len = {24'h0, 24'h332211};
    req = 2'b01;
    wait_ack(ok);
    req = '0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    q_ack.delete(); q_len.delete(); q_rsp.delete();
    rr = 0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    // req[1] raised while a stale burst is on the engine output
    do_txn(2'b10, 24'h0, 24'($urandom), 3, 1, 16'h1234, 16'h5678, 16'h9ABC, 16'h0,
           2'd3, 1'b1, lat);
    repeat (2) @(posedge clk); #1;

    // stray burst with nobody requesting: must stay idle
    stray_req++;
    repeat (6) begin
      @(posedge clk); #1;
      chk("stray_idle_busy", 64'(busy), 0);
    end

`ifdef TRI_ARB_TIMEOUT_EN
    do_txn(2'b01, 24'($urandom), 24'h0, 0, 1, 16'h0, 16'h0, 16'h0, 16'h0, 2'd0, 1'b0, lat);
    chk("timeout_latency", 64'(lat), 64'(TO + 4));
    cfg_nb = 3;
    stray_req++;
    repeat (6) begin
      @(posedge clk); #1;
      chk("late_burst_busy", 64'(busy), 0);
    end
`endif

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      nb = (r < 7) ? 3 : (r == 7) ? 2 : (r == 8) ? 4 : 1;
      rand_txn(NREQ'($urandom_range(1, 3)), nb, lat);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("rsp_queue_drained", 64'(q_rsp.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
